// File: rtl/dct_coef_reorder_quant_if.sv
// Coefficient capture side (DCT beats) and quantized natural-order output side of the reorder block.
interface dct_coef_reorder_quant_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 12
);
    logic                    in_en;
    logic signed [IN_W-1:0]  in_coef_a;
    logic [3:0]              in_idx_a;
    logic signed [IN_W-1:0]  in_coef_b;
    logic [3:0]              in_idx_b;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;
    logic [3:0]              out_idx;
    logic                    out_last;
    logic                    out_sat;
    logic                    err_overrun;
    logic                    err_dup;

    modport master (
        output in_en, in_coef_a, in_idx_a, in_coef_b, in_idx_b, out_ready,
        input  out_valid, out_data, out_idx, out_last, out_sat, err_overrun, err_dup
    );

    modport slave (
        input  in_en, in_coef_a, in_idx_a, in_coef_b, in_idx_b, out_ready,
        output out_valid, out_data, out_idx, out_last, out_sat, err_overrun, err_dup
    );
endinterface

// File: rtl/dct_coef_reorder_quant.sv
// Rounds/saturates DCT coefficient pairs into a 16-entry block, drains it in natural order 0..15 (valid 1 cycle after completing beat).
// Input has no backpressure (beats dropped when no buffer is free); output holds under !out_ready. DCT_REORDER_PINGPONG_EN selects two banks.
module dct_coef_reorder_quant #(
    parameter int IN_W  = 24,
    parameter int SHIFT = 8,
    parameter int OUT_W = 12
) (
    input  logic clk,
    input  logic reset,
    dct_coef_reorder_quant_if.slave bus
);
    typedef enum logic {S_FILL, S_DRAIN} state_t;

`ifdef DCT_REORDER_PINGPONG_EN
    localparam int AW = 5;
`else
    localparam int AW = 4;
`endif

    localparam logic signed [IN_W:0] RND  = {{IN_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [IN_W:0] QMAX = {{(IN_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [IN_W:0] QMIN = {{(IN_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    // Entry format: {sat, q}
    function automatic logic [OUT_W:0] quant(input logic signed [IN_W-1:0] c);
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] shr;
        sum = $signed({c[IN_W-1], c}) + RND;
        shr = sum >>> SHIFT;
        if (shr > QMAX)
            quant = {1'b1, QMAX[OUT_W-1:0]};
        else if (shr < QMIN)
            quant = {1'b1, QMIN[OUT_W-1:0]};
        else
            quant = {1'b0, shr[OUT_W-1:0]};
    endfunction

    logic [OUT_W:0]   mem_q [2**AW];
    state_t           state_q;
    logic [15:0]      mask_q;
    logic [3:0]       rd_ptr_q;
    logic             out_valid_q, out_last_q, out_sat_q;
    logic [OUT_W-1:0] out_data_q;
    logic [3:0]       out_idx_q;
    logic             err_overrun_q, err_dup_q;

    logic [OUT_W:0]   qa, qb, first_ent;
    logic [15:0]      mask_d;
    logic [3:0]       ptr_nx;
    logic [AW-1:0]    wa_a, wa_b, ra_first, ra_next;
    logic             wr_ok, complete, dup, hs, start;

`ifdef DCT_REORDER_PINGPONG_EN
    logic fill_q, drain_q, pend_q;

    assign wr_ok    = bus.in_en && !pend_q;
    assign start    = (state_q == S_FILL) && (complete || pend_q);
    assign wa_a     = {fill_q, bus.in_idx_a};
    assign wa_b     = {fill_q, bus.in_idx_b};
    assign ra_first = {fill_q, 4'd0};
    assign ra_next  = {drain_q, ptr_nx};
`else
    assign wr_ok    = bus.in_en && (state_q == S_FILL);
    assign start    = complete;
    assign wa_a     = bus.in_idx_a;
    assign wa_b     = bus.in_idx_b;
    assign ra_first = 4'd0;
    assign ra_next  = ptr_nx;
`endif

    assign qa       = quant(bus.in_coef_a);
    assign qb       = quant(bus.in_coef_b);
    assign mask_d   = mask_q | (16'd1 << bus.in_idx_a) | (16'd1 << bus.in_idx_b);
    assign complete = wr_ok && (&mask_d);
    assign dup      = wr_ok && ((bus.in_idx_a == bus.in_idx_b) ||
                                mask_q[bus.in_idx_a] || mask_q[bus.in_idx_b]);
    assign hs       = out_valid_q && bus.out_ready;
    assign ptr_nx   = rd_ptr_q + 4'd1;

    // Entry 0 may be written by the very beat that completes the block.
    always_comb begin
        first_ent = mem_q[ra_first];
        if (wr_ok && bus.in_idx_a == 4'd0)
            first_ent = qa;
        if (wr_ok && bus.in_idx_b == 4'd0)
            first_ent = qb;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wa_a] <= qa;
            mem_q[wa_b] <= qb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FILL;
            mask_q        <= '0;
            rd_ptr_q      <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_idx_q     <= '0;
            out_last_q    <= 1'b0;
            out_sat_q     <= 1'b0;
            err_overrun_q <= 1'b0;
            err_dup_q     <= 1'b0;
`ifdef DCT_REORDER_PINGPONG_EN
            fill_q        <= 1'b0;
            drain_q       <= 1'b0;
            pend_q        <= 1'b0;
`endif
        end else begin
            if (dup)
                err_dup_q <= 1'b1;
            if (bus.in_en && !wr_ok)
                err_overrun_q <= 1'b1;
            if (wr_ok)
                mask_q <= mask_d;

            if (start) begin
                state_q                  <= S_DRAIN;
                rd_ptr_q                 <= 4'd0;
                out_valid_q              <= 1'b1;
                out_idx_q                <= 4'd0;
                out_last_q               <= 1'b0;
                {out_sat_q, out_data_q}  <= first_ent;
`ifdef DCT_REORDER_PINGPONG_EN
                drain_q                  <= fill_q;
                fill_q                   <= ~fill_q;
                mask_q                   <= '0;
                pend_q                   <= 1'b0;
`endif
            end
`ifdef DCT_REORDER_PINGPONG_EN
            else if (complete)
                pend_q <= 1'b1;
`endif

            if (state_q == S_DRAIN && hs) begin
                if (rd_ptr_q == 4'd15) begin
                    state_q     <= S_FILL;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
`ifndef DCT_REORDER_PINGPONG_EN
                    mask_q      <= '0;
`endif
                end else begin
                    rd_ptr_q                <= ptr_nx;
                    out_idx_q               <= ptr_nx;
                    out_last_q              <= (ptr_nx == 4'd15);
                    {out_sat_q, out_data_q} <= mem_q[ra_next];
                end
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_idx     = out_idx_q;
    assign bus.out_last    = out_last_q;
    assign bus.out_sat     = out_sat_q;
    assign bus.err_overrun = err_overrun_q;
    assign bus.err_dup     = err_dup_q;
endmodule
